// File: rtl/cnn_loop_ctrl.sv
// Loop-nest sequencer for the Loop_cnn convolution datapath: walks output pixels and
// kernel taps, drives MAC clear/enable/last and buffer addresses, then writes each result.
module cnn_loop_ctrl #(
    parameter int IFM_W   = 6,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int MAC_LAT = 2,
    parameter int IFM_AW  = 6,
    parameter int WGT_AW  = 4,
    parameter int OFM_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dp_ready,
    output logic              busy,
    output logic              done,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic [IFM_AW-1:0] ifm_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic              ofm_wr,
    output logic [OFM_AW-1:0] ofm_addr,
    output logic [2:0]        state_dbg
);

    localparam int OFM_W = (IFM_W - K) / STRIDE + 1;
    localparam int OW    = $clog2(OFM_W + 1);
    localparam int KW    = $clog2(K + 1);
    localparam int DW    = $clog2(MAC_LAT + 2);

    localparam logic [OW-1:0] O_MAX     = OW'(OFM_W - 1);
    localparam logic [KW-1:0] K_MAX     = KW'(K - 1);
    localparam logic [DW-1:0] DRAIN_MAX = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state;
    logic [OW-1:0]   ox;
    logic [OW-1:0]   oy;
    logic [KW-1:0]   kx;
    logic [KW-1:0]   ky;
    logic [DW-1:0]   drain;

    logic [IFM_AW-1:0] ifm_tap;
    logic [WGT_AW-1:0] wgt_tap;
    logic [OFM_AW-1:0] ofm_pix;
    logic              tap_last;
    logic              pix_last;

    // kx/ky always name the next tap still to be issued for the current pixel.
    always_comb begin
        ifm_tap  = (IFM_AW'(oy) * IFM_AW'(STRIDE) + IFM_AW'(ky)) * IFM_AW'(IFM_W)
                   + IFM_AW'(ox) * IFM_AW'(STRIDE) + IFM_AW'(kx);
        wgt_tap  = WGT_AW'(ky) * WGT_AW'(K) + WGT_AW'(kx);
        ofm_pix  = OFM_AW'(oy) * OFM_AW'(OFM_W) + OFM_AW'(ox);
        tap_last = (kx == K_MAX) && (ky == K_MAX);
        pix_last = (ox == O_MAX) && (oy == O_MAX);
    end

    assign state_dbg = state;

    // Handshake: dp_ready high at a clock edge grants one operand, which is presented
    // in the following cycle with mac_en=1; dp_ready low at the edge presents a bubble
    // (mac_en=0) and holds the tap counters and addresses unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_last <= 1'b0;
            ifm_addr <= '0;
            wgt_addr <= '0;
            ofm_wr   <= 1'b0;
            ofm_addr <= '0;
            ox       <= '0;
            oy       <= '0;
            kx       <= '0;
            ky       <= '0;
            drain    <= '0;
        end else begin
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_last <= 1'b0;
            ofm_wr   <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLR;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        ox      <= '0;
                        oy      <= '0;
                        kx      <= '0;
                        ky      <= '0;
                    end
                end
                CLR, MAC: begin
                    if (state == MAC && mac_last) begin
                        drain <= '0;
                        if (MAC_LAT == 0) begin
                            state    <= WRITE;
                            ofm_wr   <= 1'b1;
                            ofm_addr <= ofm_pix;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        state <= MAC;
                        if (dp_ready) begin
                            mac_en   <= 1'b1;
                            mac_last <= tap_last;
                            ifm_addr <= ifm_tap;
                            wgt_addr <= wgt_tap;
                            if (!tap_last) begin
                                if (kx == K_MAX) begin
                                    kx <= '0;
                                    ky <= ky + 1'b1;
                                end else begin
                                    kx <= kx + 1'b1;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain == DRAIN_MAX) begin
                        state    <= WRITE;
                        ofm_wr   <= 1'b1;
                        ofm_addr <= ofm_pix;
                    end else begin
                        drain <= drain + 1'b1;
                    end
                end
                WRITE: begin
                    if (pix_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        if (ox == O_MAX) begin
                            ox <= '0;
                            oy <= oy + 1'b1;
                        end else begin
                            ox <= ox + 1'b1;
                        end
                        state   <= CLR;
                        mac_clr <= 1'b1;
                        kx      <= '0;
                        ky      <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_loop_ctrl.sv
// Directed bench for cnn_loop_ctrl: default geometry (6x6 map, 3x3 kernel) plus a
// second instance with K=2, STRIDE=2, MAC_LAT=0.
module tb_cnn_loop_ctrl;

    localparam int IFM_AW = 6;
    localparam int WGT_AW = 4;
    localparam int OFM_AW = 4;
    localparam logic [2:0] ST_MAC = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic dp_ready = 1'b0;
    logic busy, done, mac_clr, mac_en, mac_last, ofm_wr;
    logic [IFM_AW-1:0] ifm_addr;
    logic [WGT_AW-1:0] wgt_addr;
    logic [OFM_AW-1:0] ofm_addr;
    logic [2:0] state_dbg;

    logic start2 = 1'b0;
    logic ready2 = 1'b0;
    logic b_busy, b_done, b_mac_clr, b_mac_en, b_mac_last, b_ofm_wr;
    logic [IFM_AW-1:0] b_ifm_addr;
    logic [WGT_AW-1:0] b_wgt_addr;
    logic [OFM_AW-1:0] b_ofm_addr;
    logic [2:0] b_state_dbg;

    cnn_loop_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .dp_ready(dp_ready),
        .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_last(mac_last), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
        .ofm_wr(ofm_wr), .ofm_addr(ofm_addr), .state_dbg(state_dbg)
    );

    cnn_loop_ctrl #(.IFM_W(6), .K(2), .STRIDE(2), .MAC_LAT(0),
                    .IFM_AW(6), .WGT_AW(4), .OFM_AW(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .dp_ready(ready2),
        .busy(b_busy), .done(b_done), .mac_clr(b_mac_clr), .mac_en(b_mac_en),
        .mac_last(b_mac_last), .ifm_addr(b_ifm_addr), .wgt_addr(b_wgt_addr),
        .ofm_wr(b_ofm_wr), .ofm_addr(b_ofm_addr), .state_dbg(b_state_dbg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Pass records
    logic [IFM_AW+WGT_AW-1:0] mac_q[$];
    logic [IFM_AW+WGT_AW-1:0] exp_q[$];
    logic [OFM_AW-1:0] wr_q[$];
    int busy_cnt, done_cnt, done_cyc, stall_bad, stall_cnt, en_cnt;

    logic lg_clr[0:511];
    logic lg_en[0:511];
    logic lg_last[0:511];
    logic lg_wr[0:511];
    logic lg_busy[0:511];
    logic [IFM_AW-1:0] lg_ifm[0:511];
    logic [WGT_AW-1:0] lg_wgt[0:511];
    logic [OFM_AW-1:0] lg_oaddr[0:511];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input bit rand_ready, input bit repulse);
        int cyc;
        bit have_tap;
        logic [IFM_AW-1:0] last_ifm;
        logic [WGT_AW-1:0] last_wgt;
        mac_q.delete();
        wr_q.delete();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        stall_bad = 0; stall_cnt = 0; en_cnt = 0;
        have_tap = 1'b0; last_ifm = '0; last_wgt = '0;
        start = 1'b1;
        dp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000 && !(done_cyc >= 0 && cyc > done_cyc + 6)) begin
            if (cyc < 512) begin
                lg_clr[cyc] = mac_clr; lg_en[cyc] = mac_en; lg_last[cyc] = mac_last;
                lg_wr[cyc] = ofm_wr; lg_busy[cyc] = busy; lg_ifm[cyc] = ifm_addr;
                lg_wgt[cyc] = wgt_addr; lg_oaddr[cyc] = ofm_addr;
            end
            if (mac_en) begin
                mac_q.push_back({ifm_addr, wgt_addr});
                en_cnt++;
                have_tap = 1'b1;
                last_ifm = ifm_addr;
                last_wgt = wgt_addr;
            end else if (have_tap && state_dbg == ST_MAC) begin
                stall_cnt++;
                if (ifm_addr !== last_ifm || wgt_addr !== last_wgt) stall_bad++;
            end
            if (ofm_wr) wr_q.push_back(ofm_addr);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = 1'b0;
            if (repulse && (cyc == 40 || cyc == 120 || (done && done_cnt == 1))) start = 1'b1;
            dp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        start = 1'b0;
        dp_ready = 1'b1;
        check("pass_done_seen", 32'(done_cyc >= 0), 1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_mac_count"}, mac_q.size(), 144);
        for (int i = 0; i < 144 && i < mac_q.size(); i++)
            check({tag, "_tap"}, 32'(mac_q[i]), 32'(exp_q[i]));
        check({tag, "_wr_count"}, wr_q.size(), 16);
        for (int i = 0; i < 16 && i < wr_q.size(); i++)
            check({tag, "_wr_addr"}, 32'(wr_q[i]), i);
    endtask

    initial begin
        int p0_ifm[9];
        int cyc;
        logic [IFM_AW+WGT_AW-1:0] tap;
        logic [IFM_AW-1:0] b_q[$];
        logic [OFM_AW-1:0] b_wr[$];
        int b_done_cyc, b_done_cnt;

        p0_ifm = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        // Reference tap order for the default geometry
        for (int oy = 0; oy < 4; oy++)
            for (int ox = 0; ox < 4; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        exp_q.push_back({6'((oy + ky) * 6 + ox + kx), 4'(ky * 3 + kx)});

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr", mac_clr, 0);
        check("rst_en", mac_en, 0);
        check("rst_last", mac_last, 0);
        check("rst_ifm", ifm_addr, 0);
        check("rst_wgt", wgt_addr, 0);
        check("rst_wr", ofm_wr, 0);
        check("rst_oaddr", ofm_addr, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        tick();

        // Pass 1: no stalls, detailed timing
        run_pass(1'b0, 1'b0);
        check("p0_clr", lg_clr[1], 1);
        check("p0_no_en_in_clr", lg_en[1], 0);
        for (int i = 0; i < 9; i++) begin
            check("p0_en", lg_en[2+i], 1);
            check("p0_clr_low", lg_clr[2+i], 0);
            check("p0_ifm", lg_ifm[2+i], p0_ifm[i]);
            check("p0_wgt", lg_wgt[2+i], i);
            check("p0_last", lg_last[2+i], (i == 8) ? 1 : 0);
        end
        for (int c = 11; c <= 12; c++) begin
            check("p0_drain_en", lg_en[c], 0);
            check("p0_drain_wr", lg_wr[c], 0);
            check("p0_drain_clr", lg_clr[c], 0);
        end
        check("p0_wr", lg_wr[13], 1);
        check("p0_wr_addr", lg_oaddr[13], 0);
        check("p1_clr", lg_clr[14], 1);
        check("done_cycle", done_cyc, 209);
        check("done_count", done_cnt, 1);
        check("busy_cycles", busy_cnt, 208);
        check("busy_last", lg_busy[208], 1);
        check("busy_at_done", lg_busy[209], 0);
        check("en_count", en_cnt, 144);
        if (mac_q.size() == 144) begin
            tap = mac_q[27];
            check("pix3_first_ifm", tap[9:4], 3);
            tap = mac_q[143];
            check("pix15_last_ifm", tap[9:4], 35);
        end else begin
            check("pass1_size", mac_q.size(), 144);
        end
        check_seq("nostall");

        // Pass 2: random stalls
        run_pass(1'b1, 1'b0);
        check_seq("stall");
        check("stall_hold", stall_bad, 0);
        check("stall_seen", 32'(stall_cnt > 0), 1);
        check("stall_done_count", done_cnt, 1);

        // Pass 3: start re-pulsed while busy and in the DONE cycle
        run_pass(1'b0, 1'b1);
        check("repulse_done_count", done_cnt, 1);
        check("repulse_wr_count", wr_q.size(), 16);
        check("repulse_busy", busy_cnt, 208);
        check("repulse_done_cycle", done_cyc, 209);

        // Pass 4: reset during pixel 5 MAC phase (cycle 69 = third tap of pixel 5)
        start = 1'b1;
        dp_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (68) tick();
        check("p5_en", mac_en, 1);
        check("p5_ifm", ifm_addr, 9);
        check("p5_wgt", wgt_addr, 2);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_clr", mac_clr, 0);
        check("abort_en", mac_en, 0);
        check("abort_last", mac_last, 0);
        check("abort_ifm", ifm_addr, 0);
        check("abort_wgt", wgt_addr, 0);
        check("abort_wr", ofm_wr, 0);
        check("abort_oaddr", ofm_addr, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        run_pass(1'b0, 1'b0);
        if (mac_q.size() > 0) begin
            tap = mac_q[0];
            check("restart_ifm0", tap[9:4], 0);
        end
        check_seq("restart");
        check("restart_done_cycle", done_cyc, 209);

        // Pass 5: K=2, STRIDE=2, MAC_LAT=0 instance
        b_done_cyc = -1;
        b_done_cnt = 0;
        ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 1;
        while (cyc < 200 && !(b_done_cyc >= 0 && cyc > b_done_cyc + 4)) begin
            if (b_mac_en) b_q.push_back(b_ifm_addr);
            if (b_ofm_wr) b_wr.push_back(b_ofm_addr);
            if (b_done) begin
                b_done_cnt++;
                if (b_done_cyc < 0) b_done_cyc = cyc;
            end
            tick();
            cyc++;
        end
        check("k2_done_cycle", b_done_cyc, 55);
        check("k2_done_count", b_done_cnt, 1);
        check("k2_mac_count", b_q.size(), 36);
        check("k2_wr_count", b_wr.size(), 9);
        for (int i = 0; i < 9 && i < b_wr.size(); i++)
            check("k2_wr_addr", b_wr[i], i);
        if (b_q.size() >= 20) begin
            check("k2_pix4_t0", b_q[16], 14);
            check("k2_pix4_t1", b_q[17], 15);
            check("k2_pix4_t2", b_q[18], 20);
            check("k2_pix4_t3", b_q[19], 21);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
